// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the MIPS pipeline hazard/forwarding control.
// Encodings here are fixed by the EX-stage operand muxes.
package mips_pipe_pkg;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_EXMEM   = 2'b10;
    localparam logic [1:0] FWD_MEMWB   = 2'b01;
    localparam logic [4:0] REG_ZERO    = 5'd0;

    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
        logic       reg_write;
        logic       mem_read;
    } hazard_stage_t;

    // A stage whose result will actually land in a non-zero register.
    function automatic logic live_write(input hazard_stage_t s);
        return s.valid & s.reg_write & (s.dest != REG_ZERO);
    endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One pipeline-stage tracking register with freeze (hold) and bubble-load controls.
import mips_pipe_pkg::*;

module hazard_stage_reg (
    input  logic          clk,
    input  logic          reset,
    input  logic          hold,
    input  logic          load_bubble,
    input  hazard_stage_t d,
    output hazard_stage_t q
);

    hazard_stage_t stage_r;

    // Stage register: freeze wins over bubble, bubble wins over normal advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_r <= '0;
        end else if (hold) begin
            stage_r <= stage_r;
        end else if (load_bubble) begin
            stage_r <= '0;
        end else begin
            stage_r <= d;
        end
    end

    assign q = stage_r;

endmodule

// File: rtl/forward_hazard_unit.sv
// Hazard/forwarding controller for the 5-stage pipeline.
// FORWARDING_EN selects full forwarding with load-use stalls; otherwise stall-only interlock.
import mips_pipe_pkg::*;

module forward_hazard_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic       hold,
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic [4:0] id_dest,
    input  logic       id_reg_write,
    input  logic       id_mem_read,
    output logic [1:0] fwd_a_sel,
    output logic [1:0] fwd_b_sel,
    output logic       stall,
    output logic       bubble
);

    hazard_stage_t id_s;
    hazard_stage_t ex_q;
    hazard_stage_t mem_q;
    hazard_stage_t wb_q;
    logic          stall_s;
    logic [1:0]    fwd_a_s;
    logic [1:0]    fwd_b_s;
    logic          unused_s;

    // ID-stage fields are zeroed when the slot holds no real instruction.
    always_comb begin
        id_s = '0;
        if (id_valid) begin
            id_s.valid     = 1'b1;
            id_s.dest      = id_dest;
            id_s.reg_write = id_reg_write;
            id_s.mem_read  = id_mem_read;
        end else begin
            id_s = '0;
        end
    end

    hazard_stage_reg u_idex (
        .clk(clk), .reset(reset), .hold(hold), .load_bubble(stall_s), .d(id_s), .q(ex_q)
    );

    hazard_stage_reg u_exmem (
        .clk(clk), .reset(reset), .hold(hold), .load_bubble(1'b0), .d(ex_q), .q(mem_q)
    );

    hazard_stage_reg u_memwb (
        .clk(clk), .reset(reset), .hold(hold), .load_bubble(1'b0), .d(mem_q), .q(wb_q)
    );

`ifdef FORWARDING_EN
    logic [4:0] ex_rs_r;
    logic [4:0] ex_rt_r;
    logic       ex_uses_rt_r;

    // EX-stage source registers, advanced and bubbled alongside ID/EX.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_rs_r      <= 5'd0;
            ex_rt_r      <= 5'd0;
            ex_uses_rt_r <= 1'b0;
        end else if (hold) begin
            ex_rs_r      <= ex_rs_r;
            ex_rt_r      <= ex_rt_r;
            ex_uses_rt_r <= ex_uses_rt_r;
        end else if (stall_s || !id_valid) begin
            ex_rs_r      <= 5'd0;
            ex_rt_r      <= 5'd0;
            ex_uses_rt_r <= 1'b0;
        end else begin
            ex_rs_r      <= id_rs;
            ex_rt_r      <= id_rt;
            ex_uses_rt_r <= id_uses_rt;
        end
    end

    // Only a load in EX cannot be forwarded in time for the next instruction.
    always_comb begin
        stall_s = 1'b0;
        if (id_valid && live_write(ex_q) && ex_q.mem_read &&
            ((ex_q.dest == id_rs) || (id_uses_rt && (ex_q.dest == id_rt)))) begin
            stall_s = 1'b1;
        end else begin
            stall_s = 1'b0;
        end
    end

    // EX/MEM is checked first: it carries the youngest value of the register.
    always_comb begin
        fwd_a_s = FWD_REGFILE;
        fwd_b_s = FWD_REGFILE;
        if (live_write(mem_q) && (mem_q.dest == ex_rs_r)) begin
            fwd_a_s = FWD_EXMEM;
        end else if (live_write(wb_q) && (wb_q.dest == ex_rs_r)) begin
            fwd_a_s = FWD_MEMWB;
        end else begin
            fwd_a_s = FWD_REGFILE;
        end
        if (!ex_uses_rt_r) begin
            fwd_b_s = FWD_REGFILE;
        end else if (live_write(mem_q) && (mem_q.dest == ex_rt_r)) begin
            fwd_b_s = FWD_EXMEM;
        end else if (live_write(wb_q) && (wb_q.dest == ex_rt_r)) begin
            fwd_b_s = FWD_MEMWB;
        end else begin
            fwd_b_s = FWD_REGFILE;
        end
    end
`else
    // Without forwarding, any producer still in EX or MEM blocks the reader;
    // MEM/WB is covered by the register file writing before it is read.
    always_comb begin
        stall_s = 1'b0;
        if (id_valid &&
            ((live_write(ex_q) &&
              ((ex_q.dest == id_rs) || (id_uses_rt && (ex_q.dest == id_rt)))) ||
             (live_write(mem_q) &&
              ((mem_q.dest == id_rs) || (id_uses_rt && (mem_q.dest == id_rt)))))) begin
            stall_s = 1'b1;
        end else begin
            stall_s = 1'b0;
        end
    end

    assign fwd_a_s = FWD_REGFILE;
    assign fwd_b_s = FWD_REGFILE;
`endif

    assign unused_s  = ^{ex_q.mem_read, mem_q.mem_read, wb_q};

    assign fwd_a_sel = fwd_a_s;
    assign fwd_b_sel = fwd_b_s;
    assign stall     = stall_s;
    assign bubble    = stall_s;

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed self-checking bench for forward_hazard_unit; expectations follow FORWARDING_EN.
module tb_forward_hazard_unit;

    logic       clk;
    logic       reset;
    logic       hold;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic [4:0] id_dest;
    logic       id_reg_write;
    logic       id_mem_read;
    logic [1:0] fwd_a_sel;
    logic [1:0] fwd_b_sel;
    logic       stall;
    logic       bubble;

    int checks = 0;
    int errors = 0;

    forward_hazard_unit dut (
        .clk(clk), .reset(reset), .hold(hold),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_dest(id_dest), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall), .bubble(bubble)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic present(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                           input logic urt, input logic [4:0] dest, input logic rw,
                           input logic mr);
        id_valid = v; id_rs = rs; id_rt = rt; id_uses_rt = urt;
        id_dest = dest; id_reg_write = rw; id_mem_read = mr;
        #1;
    endtask

    task automatic nop();
        present(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        hold  = 1'b0;
        nop();
        tick();
        reset = 1'b0;
    endtask

    // Counts cycles the instruction currently presented in ID is held back (bounded).
    task automatic count_stalls(output int n);
        n = 0;
        while (stall && n < 8) begin
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        present(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b1);
        tick();
        tick();
        reset = 1'b0;
        present(1'b1, 5'd3, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
        checks++; if (bubble !== 1'b0) begin errors++; $display("FAIL reset_bubble: got %b want 0", bubble); end
        checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL reset_fwd_a: got %b want 00", fwd_a_sel); end
        checks++; if (fwd_b_sel !== 2'b00) begin errors++; $display("FAIL reset_fwd_b: got %b want 00", fwd_b_sel); end
    endtask

    // add $3,$1,$2 ; sub $4,$3,$5
    task automatic test_back_to_back();
        int n;
        logic [1:0] exp_a;
        int exp_n;
`ifdef FORWARDING_EN
        exp_a = 2'b10; exp_n = 0;
`else
        exp_a = 2'b00; exp_n = 2;
`endif
        do_reset();
        present(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
        tick();
        present(1'b1, 5'd3, 5'd5, 1'b1, 5'd4, 1'b1, 1'b0);
        checks++; if (bubble !== stall) begin errors++; $display("FAIL b2b_bubble_eq_stall: got %b want %b", bubble, stall); end
        count_stalls(n);
        checks++; if (n != exp_n) begin errors++; $display("FAIL b2b_stall_cycles: got %0d want %0d", n, exp_n); end
        tick();
        nop();
        checks++; if (fwd_a_sel !== exp_a) begin errors++; $display("FAIL b2b_fwd_a: got %b want %b", fwd_a_sel, exp_a); end
        checks++; if (fwd_b_sel !== 2'b00) begin errors++; $display("FAIL b2b_fwd_b: got %b want 00", fwd_b_sel); end
    endtask

    // add $3 ; nop ; or $6,$7,$3
    task automatic test_distance2();
        int n;
        logic [1:0] exp_b;
        int exp_n;
`ifdef FORWARDING_EN
        exp_b = 2'b01; exp_n = 0;
`else
        exp_b = 2'b00; exp_n = 1;
`endif
        do_reset();
        present(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
        tick();
        nop();
        tick();
        present(1'b1, 5'd7, 5'd3, 1'b1, 5'd6, 1'b1, 1'b0);
        count_stalls(n);
        checks++; if (n != exp_n) begin errors++; $display("FAIL dist2_stall_cycles: got %0d want %0d", n, exp_n); end
        tick();
        nop();
        checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL dist2_fwd_a: got %b want 00", fwd_a_sel); end
        checks++; if (fwd_b_sel !== exp_b) begin errors++; $display("FAIL dist2_fwd_b: got %b want %b", fwd_b_sel, exp_b); end
    endtask

    // add $3,$1,$2 ; add $3,$4,$5 ; and $8,$3,$3
    task automatic test_priority();
        int n;
        logic [1:0] exp_sel;
        int exp_n;
`ifdef FORWARDING_EN
        exp_sel = 2'b10; exp_n = 0;
`else
        exp_sel = 2'b00; exp_n = 2;
`endif
        do_reset();
        present(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
        tick();
        present(1'b1, 5'd4, 5'd5, 1'b1, 5'd3, 1'b1, 1'b0);
        count_stalls(n);
        tick();
        present(1'b1, 5'd3, 5'd3, 1'b1, 5'd8, 1'b1, 1'b0);
        count_stalls(n);
        checks++; if (n != exp_n) begin errors++; $display("FAIL prio_stall_cycles: got %0d want %0d", n, exp_n); end
        tick();
        nop();
        checks++; if (fwd_a_sel !== exp_sel) begin errors++; $display("FAIL prio_fwd_a: got %b want %b", fwd_a_sel, exp_sel); end
        checks++; if (fwd_b_sel !== exp_sel) begin errors++; $display("FAIL prio_fwd_b: got %b want %b", fwd_b_sel, exp_sel); end
    endtask

    // lw $2,0($1) ; add $4,$2,$2
    task automatic test_load_use();
        int n;
        logic [1:0] exp_sel;
        int exp_n;
`ifdef FORWARDING_EN
        exp_sel = 2'b01; exp_n = 1;
`else
        exp_sel = 2'b00; exp_n = 2;
`endif
        do_reset();
        present(1'b1, 5'd1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1);
        tick();
        present(1'b1, 5'd2, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b want 1", stall); end
        checks++; if (bubble !== 1'b1) begin errors++; $display("FAIL lu_bubble: got %b want 1", bubble); end
        count_stalls(n);
        checks++; if (n != exp_n) begin errors++; $display("FAIL lu_stall_cycles: got %0d want %0d", n, exp_n); end
        tick();
        nop();
        checks++; if (fwd_a_sel !== exp_sel) begin errors++; $display("FAIL lu_fwd_a: got %b want %b", fwd_a_sel, exp_sel); end
        checks++; if (fwd_b_sel !== exp_sel) begin errors++; $display("FAIL lu_fwd_b: got %b want %b", fwd_b_sel, exp_sel); end
    endtask

    // addi $0,$0,5 ; add $1,$0,$0 -- then the same with hold asserted in between
    task automatic test_zero_reg();
        do_reset();
        present(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        tick();
        present(1'b1, 5'd0, 5'd0, 1'b1, 5'd1, 1'b1, 1'b0);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL zero_stall: got %b want 0", stall); end
        tick();
        nop();
        checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL zero_fwd_a: got %b want 00", fwd_a_sel); end
        checks++; if (fwd_b_sel !== 2'b00) begin errors++; $display("FAIL zero_fwd_b: got %b want 00", fwd_b_sel); end
        do_reset();
        present(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        tick();
        hold = 1'b1;
        present(1'b1, 5'd0, 5'd0, 1'b1, 5'd1, 1'b1, 1'b0);
        tick();
        tick();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL zero_hold_stall: got %b want 0", stall); end
        hold = 1'b0;
        tick();
        nop();
        checks++; if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin
            errors++; $display("FAIL zero_hold_fwd: got %b/%b want 00/00", fwd_a_sel, fwd_b_sel);
        end
    endtask

    // add $3 ; sub $4,$3,$5 with hold for two cycles: nothing may advance
    task automatic test_hold();
        int n;
        logic exp_stall;
        logic [1:0] exp_a;
        int exp_n;
`ifdef FORWARDING_EN
        exp_stall = 1'b0; exp_a = 2'b10; exp_n = 0;
`else
        exp_stall = 1'b1; exp_a = 2'b00; exp_n = 2;
`endif
        do_reset();
        present(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
        tick();
        hold = 1'b1;
        present(1'b1, 5'd3, 5'd5, 1'b1, 5'd4, 1'b1, 1'b0);
        tick();
        checks++; if (stall !== exp_stall) begin errors++; $display("FAIL hold_stall_1: got %b want %b", stall, exp_stall); end
        tick();
        checks++; if (stall !== exp_stall) begin errors++; $display("FAIL hold_stall_2: got %b want %b", stall, exp_stall); end
        hold = 1'b0;
        #1;
        count_stalls(n);
        checks++; if (n != exp_n) begin errors++; $display("FAIL hold_stall_cycles: got %0d want %0d", n, exp_n); end
        tick();
        nop();
        checks++; if (fwd_a_sel !== exp_a) begin errors++; $display("FAIL hold_fwd_a: got %b want %b", fwd_a_sel, exp_a); end
    endtask

    // lw $2 ; add $4,$2,$2 -- reset lands while the stall is pending
    task automatic test_reset_mid_stall();
        do_reset();
        present(1'b1, 5'd1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1);
        tick();
        present(1'b1, 5'd2, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rms_pre_stall: got %b want 1", stall); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rms_stall: got %b want 0", stall); end
        checks++; if (bubble !== 1'b0) begin errors++; $display("FAIL rms_bubble: got %b want 0", bubble); end
        tick();
        nop();
        checks++; if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin
            errors++; $display("FAIL rms_fwd: got %b/%b want 00/00", fwd_a_sel, fwd_b_sel);
        end
    endtask

    initial begin
        reset = 1'b1;
        hold  = 1'b0;
        id_valid = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
        id_dest = 5'd0; id_reg_write = 1'b0; id_mem_read = 1'b0;
        test_reset();
        test_back_to_back();
        test_distance2();
        test_priority();
        test_load_use();
        test_zero_reg();
        test_hold();
        test_reset_mid_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
